// File: rtl/imem_arbiter.sv
// Instruction memory arbiter: shares one synchronous-read port between
// fetch and the loader, with starvation relief and a loader lock mode.
module imem_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_rvalid,
   output logic [31:0]       fetch_rdata,
   output logic              fetch_stall,
   input  logic              ldr_lock,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [31:0]       ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_rvalid,
   output logic [31:0]       ldr_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic {
      S_RUN,
      S_LOAD
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_FETCH,
      OWN_LDR
   } owner_t;

   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   state_t      state_q, state_d;
   owner_t      owner_q, owner_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic        fetch_win;
   logic        ldr_win;
   logic        ldr_starved;

   assign ldr_starved = (wait_cnt_q == WAIT_MAX);

   always_comb begin
      fetch_win = 1'b0;
      ldr_win   = 1'b0;
      case (state_q)
         S_RUN: begin
            ldr_win   = ldr_req && (!fetch_req || ldr_starved);
            fetch_win = fetch_req && !ldr_win;
         end
         S_LOAD: begin
            ldr_win = ldr_req;
         end
         default: begin
            fetch_win = 1'b0;
            ldr_win   = 1'b0;
         end
      endcase
   end

   assign fetch_gnt   = fetch_win;
   assign ldr_gnt     = ldr_win;
   assign fetch_stall = (state_q == S_LOAD);

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (ldr_win) begin
         mem_addr  = ldr_addr;
         mem_we    = ldr_we;
         mem_wdata = ldr_wdata;
      end else if (fetch_win) begin
         mem_addr = fetch_addr;
      end
   end

   always_comb begin
      state_d    = ldr_lock ? S_LOAD : S_RUN;
      owner_d    = OWN_NONE;
      wait_cnt_d = '0;
      if (fetch_win) begin
         owner_d = OWN_FETCH;
      end else if (ldr_win && !ldr_we) begin
         owner_d = OWN_LDR;
      end
      // only a denied loader request in RUN accumulates wait
      if (state_q == S_RUN && ldr_req && !ldr_win) begin
         wait_cnt_d = ldr_starved ? wait_cnt_q : wait_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_RUN;
         owner_q    <= OWN_NONE;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // a read issued just before reset must not surface during reset
   assign fetch_rvalid = (owner_q == OWN_FETCH) && !rst;
   assign ldr_rvalid   = (owner_q == OWN_LDR) && !rst;
   assign fetch_rdata  = fetch_rvalid ? mem_rdata : '0;
   assign ldr_rdata    = ldr_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a synchronous-read memory model.
module tb_imem_arbiter;

   localparam int ADDR_W = 10;

   logic              clk;
   logic              rst;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_gnt;
   logic              fetch_rvalid;
   logic [31:0]       fetch_rdata;
   logic              fetch_stall;
   logic              ldr_lock;
   logic              ldr_req;
   logic              ldr_we;
   logic [ADDR_W-1:0] ldr_addr;
   logic [31:0]       ldr_wdata;
   logic              ldr_gnt;
   logic              ldr_rvalid;
   logic [31:0]       ldr_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   logic [31:0] mem [1024];
   int n_vec;
   int n_err;

   imem_arbiter #(
      .ADDR_W  (ADDR_W),
      .MAX_WAIT(4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_gnt   (fetch_gnt),
      .fetch_rvalid(fetch_rvalid),
      .fetch_rdata (fetch_rdata),
      .fetch_stall (fetch_stall),
      .ldr_lock    (ldr_lock),
      .ldr_req     (ldr_req),
      .ldr_we      (ldr_we),
      .ldr_addr    (ldr_addr),
      .ldr_wdata   (ldr_wdata),
      .ldr_gnt     (ldr_gnt),
      .ldr_rvalid  (ldr_rvalid),
      .ldr_rdata   (ldr_rdata),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   function automatic logic [31:0] pat(input int a);
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = pat(i);
      mem_rdata = '0;
   end

   // read-first synchronous memory
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   // fetch and loader read of 0x3F both held; loader wins on the 5th cycle
   task automatic contend(input string tag);
      for (int c = 0; c < 5; c++) begin
         settle;
         chk({tag, " ldr_gnt"}, 32'(ldr_gnt), 32'(c == 4));
         chk({tag, " fetch_gnt"}, 32'(fetch_gnt), 32'(c != 4));
         if (c == 1) chk({tag, " fetch_rdata"}, fetch_rdata, pat(32'h20));
         if (c == 4) chk({tag, " mem_addr"}, 32'(mem_addr), 32'h3F);
         cyc;
      end
      ldr_req = 1'b0;
      settle;
      chk({tag, " ldr_rvalid"}, 32'(ldr_rvalid), 32'd1);
      chk({tag, " ldr_rdata"}, ldr_rdata, pat(32'h3F));
      chk({tag, " fetch_rdata0"}, fetch_rdata, 32'd0);
      chk({tag, " fetch_gnt_after"}, 32'(fetch_gnt), 32'd1);
      cyc;
      fetch_req = 1'b0;
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      rst        = 1'b1;
      fetch_req  = 1'b0;
      fetch_addr = '0;
      ldr_lock   = 1'b0;
      ldr_req    = 1'b0;
      ldr_we     = 1'b0;
      ldr_addr   = '0;
      ldr_wdata  = '0;
      cyc;
      cyc;
      settle;
      chk("rst fetch_gnt", 32'(fetch_gnt), 32'd0);
      chk("rst ldr_gnt", 32'(ldr_gnt), 32'd0);
      chk("rst fetch_rvalid", 32'(fetch_rvalid), 32'd0);
      chk("rst ldr_rvalid", 32'(ldr_rvalid), 32'd0);
      chk("rst fetch_stall", 32'(fetch_stall), 32'd0);
      chk("rst fetch_rdata", fetch_rdata, 32'd0);
      chk("rst ldr_rdata", ldr_rdata, 32'd0);
      chk("rst mem_addr", 32'(mem_addr), 32'd0);
      chk("rst mem_we", 32'(mem_we), 32'd0);
      chk("rst mem_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      cyc;

      // fetch stream 0..7
      for (int i = 0; i < 8; i++) begin
         fetch_req  = 1'b1;
         fetch_addr = ADDR_W'(i);
         settle;
         chk("seq fetch_gnt", 32'(fetch_gnt), 32'd1);
         chk("seq mem_addr", 32'(mem_addr), 32'(i));
         chk("seq ldr_rvalid", 32'(ldr_rvalid), 32'd0);
         chk("seq fetch_rvalid", 32'(fetch_rvalid), 32'(i > 0));
         if (i > 0) chk("seq fetch_rdata", fetch_rdata, pat(i - 1));
         cyc;
      end
      fetch_req = 1'b0;
      settle;
      chk("seq last rvalid", 32'(fetch_rvalid), 32'd1);
      chk("seq last rdata", fetch_rdata, pat(7));
      cyc;
      settle;
      chk("seq idle rvalid", 32'(fetch_rvalid), 32'd0);

      // starvation relief
      fetch_req  = 1'b1;
      fetch_addr = ADDR_W'(32'h20);
      ldr_req    = 1'b1;
      ldr_we     = 1'b0;
      ldr_addr   = ADDR_W'(32'h3F);
      contend("starve");

      // lock rise with a fetch read in the same cycle
      fetch_req  = 1'b1;
      fetch_addr = ADDR_W'(5);
      ldr_lock   = 1'b1;
      settle;
      chk("lock0 fetch_gnt", 32'(fetch_gnt), 32'd1);
      chk("lock0 stall", 32'(fetch_stall), 32'd0);
      cyc;
      ldr_req   = 1'b1;
      ldr_we    = 1'b1;
      ldr_addr  = ADDR_W'(32'h10);
      ldr_wdata = 32'hDEADBEEF;
      settle;
      chk("lock1 stall", 32'(fetch_stall), 32'd1);
      chk("lock1 fetch_gnt", 32'(fetch_gnt), 32'd0);
      chk("lock1 fetch_rvalid", 32'(fetch_rvalid), 32'd1);
      chk("lock1 fetch_rdata", fetch_rdata, pat(5));
      chk("lock1 ldr_gnt", 32'(ldr_gnt), 32'd1);
      chk("lock1 mem_we", 32'(mem_we), 32'd1);
      chk("lock1 mem_wdata", mem_wdata, 32'hDEADBEEF);
      cyc;
      ldr_addr  = ADDR_W'(32'h11);
      ldr_wdata = 32'h12345678;
      settle;
      chk("lock2 fetch_gnt", 32'(fetch_gnt), 32'd0);
      chk("lock2 fetch_rvalid", 32'(fetch_rvalid), 32'd0);
      chk("lock2 ldr_rvalid", 32'(ldr_rvalid), 32'd0);
      chk("lock2 mem_addr", 32'(mem_addr), 32'h11);
      cyc;
      ldr_we   = 1'b0;
      ldr_addr = ADDR_W'(32'h10);
      ldr_lock = 1'b0;
      settle;
      chk("lock3 ldr_gnt", 32'(ldr_gnt), 32'd1);
      chk("lock3 fetch_gnt", 32'(fetch_gnt), 32'd0);
      chk("lock3 stall", 32'(fetch_stall), 32'd1);
      cyc;
      ldr_req    = 1'b0;
      fetch_addr = ADDR_W'(32'h10);
      settle;
      chk("unlock stall", 32'(fetch_stall), 32'd0);
      chk("unlock ldr_rvalid", 32'(ldr_rvalid), 32'd1);
      chk("unlock ldr_rdata", ldr_rdata, 32'hDEADBEEF);
      chk("unlock fetch_gnt", 32'(fetch_gnt), 32'd1);
      cyc;
      fetch_addr = ADDR_W'(32'h11);
      settle;
      chk("rd10 fetch_rdata", fetch_rdata, 32'hDEADBEEF);
      chk("rd10 ldr_rvalid", 32'(ldr_rvalid), 32'd0);
      cyc;
      fetch_req = 1'b0;
      settle;
      chk("rd11 fetch_rdata", fetch_rdata, 32'h12345678);
      cyc;

      // partial wait build-up, then reset during contention
      fetch_req  = 1'b1;
      fetch_addr = ADDR_W'(32'h20);
      ldr_req    = 1'b1;
      ldr_we     = 1'b0;
      ldr_addr   = ADDR_W'(32'h3F);
      settle;
      chk("pre0 fetch_gnt", 32'(fetch_gnt), 32'd1);
      cyc;
      settle;
      chk("pre1 fetch_gnt", 32'(fetch_gnt), 32'd1);
      cyc;
      rst = 1'b1;
      settle;
      chk("rstcyc fetch_rvalid", 32'(fetch_rvalid), 32'd0);
      chk("rstcyc fetch_rdata", fetch_rdata, 32'd0);
      cyc;
      rst = 1'b0;
      settle;
      chk("postrst fetch_rvalid", 32'(fetch_rvalid), 32'd0);
      chk("postrst ldr_rvalid", 32'(ldr_rvalid), 32'd0);
      chk("postrst stall", 32'(fetch_stall), 32'd0);
      contend("postrst");

      settle;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
